// File: rtl/serial_comp_ctrl.sv
// ---------------------------------------------------------------------------
// serial_comp_ctrl : sequences two WIDTH-bit words through a bit-serial L/E/G comparator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_comp_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             err,
   output logic             sc_reset,
   output logic             sc_a,
   output logic             sc_b,
   input  logic             sc_L,
   input  logic             sc_E,
   input  logic             sc_G
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CLR    = 2'd1,
      S_SHIFT  = 2'd2,
      S_SAMPLE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, err_q, err_d;

   logic             a_head, b_head;
   logic [WIDTH-1:0] a_next, b_next;
   logic             lge_onehot;

   // Head bit and shift direction follow the comparator's significance order.
   generate
      if (LSB_FIRST) begin : g_lsb_first
         assign a_head = a_sh_q[0];
         assign b_head = b_sh_q[0];
         assign a_next = {1'b0, a_sh_q[WIDTH-1:1]};
         assign b_next = {1'b0, b_sh_q[WIDTH-1:1]};
      end else begin : g_msb_first
         assign a_head = a_sh_q[WIDTH-1];
         assign b_head = b_sh_q[WIDTH-1];
         assign a_next = {a_sh_q[WIDTH-2:0], 1'b0};
         assign b_next = {b_sh_q[WIDTH-2:0], 1'b0};
      end
   endgenerate

   assign lge_onehot = ({sc_L, sc_E, sc_G} == 3'b100) ||
                       ({sc_L, sc_E, sc_G} == 3'b010) ||
                       ({sc_L, sc_E, sc_G} == 3'b001);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a_word;
               b_sh_d  = b_word;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            a_sh_d = a_next;
            b_sh_d = b_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // Captured as-is even when not one-hot; err flags the anomaly.
            lt_d    = sc_L;
            eq_d    = sc_E;
            gt_d    = sc_G;
            err_d   = ~lge_onehot;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         err_q   <= err_d;
      end
   end

   // The comparator is cleared alongside the controller and kept quiet outside SHIFT.
   assign sc_reset = ~reset | (state_q == S_CLR);
   assign sc_a     = (state_q == S_SHIFT) ? a_head : 1'b0;
   assign sc_b     = (state_q == S_SHIFT) ? b_head : 1'b0;

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;
   assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_comp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_comp_ctrl : scoreboard bench with an LSB-first serial comparator stub
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_comp_ctrl;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
      logic err;
   } res_t;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a_word, b_word;
   logic             busy, done, lt, eq, gt, err;
   logic             sc_reset, sc_a, sc_b;
   logic             sc_L, sc_E, sc_G;
   logic             force_bad;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_q[$];

   serial_comp_ctrl #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .a_word   (a_word),
      .b_word   (b_word),
      .busy     (busy),
      .done     (done),
      .lt       (lt),
      .eq       (eq),
      .gt       (gt),
      .err      (err),
      .sc_reset (sc_reset),
      .sc_a     (sc_a),
      .sc_b     (sc_b),
      .sc_L     (sc_L),
      .sc_E     (sc_E),
      .sc_G     (sc_G)
   );

   always #5 clock = ~clock;

   // LSB-first comparator: later (more significant) differing bits override.
   logic [1:0] cmp_q;  // 0 = E, 1 = L, 2 = G
   always_ff @(posedge clock) begin
      if (sc_reset)           cmp_q <= 2'd0;
      else if (sc_a && !sc_b) cmp_q <= 2'd2;
      else if (!sc_a && sc_b) cmp_q <= 2'd1;
   end
   assign sc_L = force_bad ? 1'b1 : (cmp_q == 2'd1);
   assign sc_E = force_bad ? 1'b0 : (cmp_q == 2'd0);
   assign sc_G = force_bad ? 1'b1 : (cmp_q == 2'd2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every done pops one expected result.
   always @(negedge clock) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("result_lt_eq_gt_err", {28'd0, lt, eq, gt, err}, {28'd0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Waits after an accepting edge; reports edges taken until done.
   task automatic wait_done(input int max_edges, output int edges);
      edges = 0;
      while (edges < max_edges) begin
         tick();
         edges++;
         if (done) break;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input res_t e);
      int edges;
      a_word = a;
      b_word = b;
      start  = 1'b1;
      exp_q.push_back(e);
      tick();
      start  = 1'b0;
      a_word = ~a;
      b_word = ~b;
      wait_done(WIDTH + 8, edges);
      chk("latency", edges, WIDTH + 2);
   endtask

   initial begin
      int edges;
      int n_done;
      logic [WIDTH-1:0] va, vb;
      reset = 1'b0; start = 1'b0; a_word = '0; b_word = '0; force_bad = 1'b0;

      // Reset
      tick(); tick();
      chk("rst_sc_reset", sc_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_results", {lt, eq, gt, err}, 0);
      reset = 1'b1;
      #1;
      chk("rel_sc_reset", sc_reset, 0);
      tick();
      chk("idle_sc_ab", {sc_a, sc_b}, 0);

      // A=1010, B=0110: serial bit check
      va = 4'b1010; vb = 4'b0110;
      a_word = va; b_word = vb; start = 1'b1;
      exp_q.push_back('{lt:1'b0, eq:1'b0, gt:1'b1, err:1'b0});
      tick();
      start = 1'b0; a_word = '0; b_word = '0;
      chk("clr_busy", busy, 1);
      chk("clr_sc_reset", sc_reset, 1);
      chk("clr_sc_ab", {sc_a, sc_b}, 0);
      for (int i = 0; i < WIDTH; i++) begin
         tick();
         chk("shift_sc_a", sc_a, va[i]);
         chk("shift_sc_b", sc_b, vb[i]);
         chk("shift_sc_reset", sc_reset, 0);
      end
      tick();
      chk("sample_sc_ab", {sc_a, sc_b}, 0);
      chk("sample_busy_done", {busy, done}, 2'b10);
      tick();
      chk("done_pulse", {busy, done}, 2'b01);
      tick();
      chk("done_one_cycle", done, 0);
      chk("hold_gt", {lt, eq, gt, err}, 4'b0010);

      // Back-to-back: 3 vs 9 then 7 vs 7, start held through done cycle
      a_word = 4'd3; b_word = 4'd9; start = 1'b1;
      exp_q.push_back('{lt:1'b1, eq:1'b0, gt:1'b0, err:1'b0});
      exp_q.push_back('{lt:1'b0, eq:1'b1, gt:1'b0, err:1'b0});
      tick();
      a_word = 4'd7; b_word = 4'd7;
      wait_done(WIDTH + 8, edges);
      chk("b2b_first_latency", edges, WIDTH + 2);
      tick();
      start = 1'b0;
      chk("b2b_no_bubble", {busy, sc_reset}, 2'b11);
      wait_done(WIDTH + 8, edges);
      chk("b2b_second_latency", edges, WIDTH + 2);

      // Start while busy is ignored
      a_word = 4'd12; b_word = 4'd5; start = 1'b1;
      exp_q.push_back('{lt:1'b0, eq:1'b0, gt:1'b1, err:1'b0});
      tick();
      start = 1'b0;
      tick();
      a_word = 4'd1; b_word = 4'd14; start = 1'b1;
      tick();
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 3 * WIDTH; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("ignored_start_one_done", n_done, 1);
      chk("ignored_start_result", {lt, eq, gt, err}, 4'b0010);

      // Reset during 2nd SHIFT cycle
      a_word = 4'd9; b_word = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("midrst_sc_reset", sc_reset, 1);
      tick();
      chk("midrst_busy", busy, 0);
      chk("midrst_results", {lt, eq, gt, err, done}, 0);
      reset = 1'b1;
      n_done = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("midrst_no_done", n_done, 0);
      run_cmp(4'd0, 4'd15, '{lt:1'b1, eq:1'b0, gt:1'b0, err:1'b0});

      // Non-one-hot comparator outputs
      force_bad = 1'b1;
      run_cmp(4'd5, 4'd5, '{lt:1'b1, eq:1'b0, gt:1'b1, err:1'b1});
      force_bad = 1'b0;
      tick(); tick();
      chk("err_held", err, 1);
      run_cmp(4'd2, 4'd2, '{lt:1'b0, eq:1'b1, gt:1'b0, err:1'b0});
      tick();
      chk("err_cleared", {lt, eq, gt, err}, 4'b0100);

      // MSB decides over LSB difference
      run_cmp(4'b1000, 4'b0111, '{lt:1'b0, eq:1'b0, gt:1'b1, err:1'b0});

      tick(); tick();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
